// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input and instruction-memory write bus shared by
//               the program-image loader and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 64
) ();

  // Byte stream from the host (valid/ready)
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;

  // Byte write port into instruction memory
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Environment side: drives the stream, observes the memory writes
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  // Loader side: consumes the stream, drives the memory writes
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Receives a byte-serial Y86 program image (LEN_LO, LEN_HI,
//               payload[, checksum]) over a valid/ready stream and writes the
//               payload byte-by-byte into instruction memory starting at
//               BASE_ADDR. Holds the CPU until the image is loaded.
//               Optional trailing XOR checksum: define IMEM_LOADER_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic [15:0] byte_count,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM  = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // State entered once the last payload byte (or an empty payload) is seen
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_t c_after_payload = S_CKSUM;
`else
  localparam state_t c_after_payload = S_DONE;
`endif

  localparam logic [31:0] c_mem_bytes = 32'(MEM_BYTES);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_len;
  logic [15:0]       r_byte_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_in_ready;
  logic              w_hs;
  logic              w_wr;
  logic              w_lat_lo;
  logic              w_lat_hi;
  logic              w_clear;
  logic [15:0]       w_len_full;

  // State register; reset abandons any image in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LEN_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state != S_DONE) && (r_state != S_ERR);
    w_hs        = bus.in_valid & w_in_ready;
    w_wr        = 1'b0;
    w_lat_lo    = 1'b0;
    w_lat_hi    = 1'b0;
    w_clear     = 1'b0;
    w_len_full  = {bus.in_data, r_len[7:0]};

    case (r_state)
      S_LEN_LO: begin
        if (w_hs) begin
          w_lat_lo    = 1'b1;
          w_state_nxt = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_hs) begin
          w_lat_hi = 1'b1;
          if ({16'd0, w_len_full} > c_mem_bytes) begin
            w_state_nxt = S_ERR;
          end else if (w_len_full == 16'd0) begin
            w_state_nxt = c_after_payload;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_hs) begin
          w_wr = 1'b1;
          // byte_count is the index of this byte, so +1 is the running total
          if (r_byte_count + 16'd1 == r_len) begin
            w_state_nxt = c_after_payload;
          end
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (w_hs) begin
          w_state_nxt = (bus.in_data == r_xor) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_LEN_LO;
        end
      end
      default: begin
        w_state_nxt = S_LEN_LO;
      end
    endcase
  end

  // Length capture, registered memory write and payload bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len        <= 16'd0;
      r_byte_count <= 16'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= 8'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_xor        <= 8'd0;
`endif
    end else begin
      r_mem_we <= w_wr;
      if (w_lat_lo) begin
        r_len[7:0] <= bus.in_data;
      end
      if (w_lat_hi) begin
        r_len[15:8] <= bus.in_data;
      end
      if (w_wr) begin
        r_mem_addr   <= BASE_ADDR + ADDR_W'(r_byte_count);
        r_mem_wdata  <= bus.in_data;
        r_byte_count <= r_byte_count + 16'd1;
`ifdef IMEM_LOADER_CKSUM_EN
        r_xor        <= r_xor ^ bus.in_data;
`endif
      end
      if (w_clear) begin
        r_len        <= 16'd0;
        r_byte_count <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
        r_xor        <= 8'd0;
`endif
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  assign byte_count = r_byte_count;
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERR);
  assign cpu_hold   = ~load_done;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader. Streams are
//               extended with the XOR trailer when IMEM_LOADER_CKSUM_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] byte_count;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
    int          cyc;
    logic        done;
    logic        hold;
  } wr_t;

  wr_t wlog[$];

  imem_loader_if #(.ADDR_W(64)) bus ();

  imem_loader #(
    .ADDR_W   (64),
    .BASE_ADDR(64'h0),
    .MEM_BYTES(1024)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .byte_count(byte_count),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Cycle stamp for write-spacing checks
  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write away from the active edge
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wlog.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, cyc: cyc,
                       done: load_done, hold: cpu_hold});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offer one byte; returns 1ns after the handshake edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 64'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_mem_wdata: got %h want 00", bus.mem_wdata); end
    total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL rst_byte_count: got %0d want 0", byte_count); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_load_done: got %b want 0", load_done); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err: got %b want 0", load_err); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3] = '{8'h30, 8'hF2, 8'h0A};
    wlog.delete();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h30); send_byte(8'hF2); send_byte(8'h0A);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'hC8);
`endif
    @(negedge clk); @(negedge clk);
    total++; if (wlog.size() !== 3) begin bad++; $display("FAIL basic_nwrites: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wlog.size()) begin
        total++; if (wlog[i].addr !== 64'(i)) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, wlog[i].addr, i); end
        total++; if (wlog[i].data !== exp_d[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, wlog[i].data, exp_d[i]); end
        if (i > 0) begin
          total++; if (wlog[i].cyc !== wlog[i-1].cyc + 1) begin bad++; $display("FAIL basic_b2b[%0d]: got gap %0d want 1", i, wlog[i].cyc - wlog[i-1].cyc); end
        end
      end
    end
    if (wlog.size() > 0) begin
      total++; if (wlog[0].hold !== 1'b1) begin bad++; $display("FAIL basic_hold_during: got %b want 1", wlog[0].hold); end
    end
`ifndef IMEM_LOADER_CKSUM_EN
    if (wlog.size() > 2) begin
      total++; if (wlog[2].done !== 1'b1) begin bad++; $display("FAIL basic_done_with_last: got %b want 1", wlog[2].done); end
    end
`endif
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL basic_load_done: got %b want 1", load_done); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL basic_load_err: got %b want 0", load_err); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready: got %b want 0", bus.in_ready); end
    total++; if (byte_count !== 16'd3) begin bad++; $display("FAIL basic_byte_count: got %0d want 3", byte_count); end
  endtask

  task automatic test_oversize();
    do_reset();
    wlog.delete();
    send_byte(8'h01); send_byte(8'h04);
    @(negedge clk);
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL over_load_err: got %b want 1", load_err); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL over_load_done: got %b want 0", load_done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL over_cpu_hold: got %b want 1", cpu_hold); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL over_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    total++; if (wlog.size() !== 0) begin bad++; $display("FAIL over_nwrites: got %0d want 0", wlog.size()); end
    // Exactly MEM_BYTES is a legal length
    do_reset();
    send_byte(8'h00); send_byte(8'h04);
    @(negedge clk);
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL max_len_err: got %b want 0", load_err); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL max_len_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_gaps();
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] s [5] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
`else
    logic [7:0] s [4] = '{8'h02, 8'h00, 8'h11, 8'h22};
`endif
    do_reset();
    wlog.delete();
    foreach (s[i]) begin
      send_byte(s[i]);
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
    total++; if (wlog.size() !== 2) begin bad++; $display("FAIL gap_nwrites: got %0d want 2", wlog.size()); end
    if (wlog.size() > 1) begin
      total++; if (wlog[0].addr !== 64'h0 || wlog[0].data !== 8'h11) begin bad++; $display("FAIL gap_w0: got %h@%h want 11@0", wlog[0].data, wlog[0].addr); end
      total++; if (wlog[1].addr !== 64'h1 || wlog[1].data !== 8'h22) begin bad++; $display("FAIL gap_w1: got %h@%h want 22@1", wlog[1].data, wlog[1].addr); end
      total++; if (wlog[1].cyc - wlog[0].cyc !== 4) begin bad++; $display("FAIL gap_spacing: got %0d want 4", wlog[1].cyc - wlog[0].cyc); end
    end
    total++; if (byte_count !== 16'd2) begin bad++; $display("FAIL gap_byte_count: got %0d want 2", byte_count); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL gap_load_done: got %b want 1", load_done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wlog.delete();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'hA1); send_byte(8'hA2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL mid_mem_we: got %b want 0", bus.mem_we); end
    total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL mid_byte_count: got %0d want 0", byte_count); end
    total++; if (bus.mem_addr !== 64'h0) begin bad++; $display("FAIL mid_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (wlog.size() !== 2) begin bad++; $display("FAIL mid_nwrites: got %0d want 2", wlog.size()); end
    wlog.delete();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'hAA);
`endif
    @(negedge clk); @(negedge clk);
    total++; if (wlog.size() !== 1) begin bad++; $display("FAIL mid_new_nwrites: got %0d want 1", wlog.size()); end
    if (wlog.size() > 0) begin
      total++; if (wlog[0].addr !== 64'h0 || wlog[0].data !== 8'hAA) begin bad++; $display("FAIL mid_new_w0: got %h@%h want AA@0", wlog[0].data, wlog[0].addr); end
    end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL mid_new_done: got %b want 1", load_done); end
  endtask

  task automatic test_zero_len();
    do_reset();
    wlog.delete();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", load_done); end
    total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL zero_byte_count: got %0d want 0", byte_count); end
    @(negedge clk);
    total++; if (wlog.size() !== 0) begin bad++; $display("FAIL zero_nwrites: got %0d want 0", wlog.size()); end
  endtask

  task automatic test_start_ignored();
    do_reset();
    wlog.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h22);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h33);
`endif
    @(negedge clk); @(negedge clk);
    total++; if (byte_count !== 16'd2) begin bad++; $display("FAIL ign_byte_count: got %0d want 2", byte_count); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", load_done); end
    if (wlog.size() > 1) begin
      total++; if (wlog[1].addr !== 64'h1) begin bad++; $display("FAIL ign_addr1: got %h want 1", wlog[1].addr); end
    end
  endtask

  task automatic test_restart();
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rs_ready_on_start: got %b want 0", bus.in_ready); end
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rs_done_cleared: got %b want 0", load_done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rs_hold: got %b want 1", cpu_hold); end
    total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL rs_count_cleared: got %0d want 0", byte_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rs_ready: got %b want 1", bus.in_ready); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h55);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h55);
`endif
    @(negedge clk); @(negedge clk);
    total++; if (wlog.size() !== 1) begin bad++; $display("FAIL rs_nwrites: got %0d want 1", wlog.size()); end
    if (wlog.size() > 0) begin
      total++; if (wlog[0].addr !== 64'h0 || wlog[0].data !== 8'h55) begin bad++; $display("FAIL rs_w0: got %h@%h want 55@0", wlog[0].data, wlog[0].addr); end
    end
    total++; if (byte_count !== 16'd1) begin bad++; $display("FAIL rs_byte_count: got %0d want 1", byte_count); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL rs_done: got %b want 1", load_done); end
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_cksum_bad();
    do_reset();
    wlog.delete();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h30); send_byte(8'hF2); send_byte(8'h0A); send_byte(8'h00);
    @(negedge clk);
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL ck_err: got %b want 1", load_err); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL ck_done: got %b want 0", load_done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL ck_hold: got %b want 1", cpu_hold); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_oversize();
    test_gaps();
    test_reset_mid();
    test_zero_len();
    test_start_ignored();
    test_restart();
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum_bad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
